// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine credit/payout path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package slot_pkg;

  localparam int BET_W  = 4;
  localparam int REEL_W = 10;
  localparam int BCD_W  = 12;
  localparam int DD_W   = BCD_W + REEL_W;
  localparam int MULT_W = 6;

  localparam logic [MULT_W-1:0] MULT_JACKPOT = 6'd50;
  localparam logic [MULT_W-1:0] MULT_TRIPLE  = 6'd10;
  localparam logic [MULT_W-1:0] MULT_WIN     = 6'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RES = 3'd1,
    CONVERT  = 3'd2,
    PAYOUT   = 3'd3,
    CASHOUT  = 3'd4
  } credit_state_t;

  // One double-dabble iteration: add 3 to every BCD digit >= 5, then shift left.
  // The hundreds-digit carry falls off the top, so values above 999 keep
  // only their low three decimal digits.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] s);
    logic [DD_W-1:0] t;
    t = s;
    for (int d = 0; d < 3; d++) begin
      if (t[REEL_W + 4*d +: 4] >= 4'd5) begin
        t[REEL_W + 4*d +: 4] = t[REEL_W + 4*d +: 4] + 4'd3;
      end
    end
    return {t[DD_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 10-bit binary to 3-digit BCD converter (double-dabble).
// Latency: go sampled at edge 0 loads and shifts once; o_done pulses after the 10th shift.
// Backpressure: none; a new go restarts the conversion, digits hold until then.
module bin2bcd_seq
  import slot_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_go,
  input  logic [REEL_W-1:0] i_bin,
  output logic              o_done,
  output logic [BCD_W-1:0]  o_bcd
);

  logic [DD_W-1:0] r_sh;
  logic [3:0]      r_cnt;
  logic            r_done;

  // Load with the first shift folded in, then one shift per cycle for the rest
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh   <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_go) begin
        r_sh  <= dd_step({{BCD_W{1'b0}}, i_bin});
        r_cnt <= 4'(REEL_W - 1);
      end else if (r_cnt != 4'd0) begin
        r_sh   <= dd_step(r_sh);
        r_cnt  <= r_cnt - 4'd1;
        r_done <= (r_cnt == 4'd1);
      end
    end
  end

  assign o_done = r_done;
  assign o_bcd  = r_sh[DD_W-1 -: BCD_W];

endmodule

// File: rtl/slot_credit_ctrl.sv
// Credit/payout controller: debits bets, starts spins, pays wins, drains cash-out via hopper.
// Latency: start/reject 1 cycle after spin_req; win credited 12 cycles after res_valid.
// Backpressure: spins refused (reject) when busy-free checks fail; hopper paces cash-out by ack.
module slot_credit_ctrl
  import slot_pkg::*;
#(
  parameter int CREDIT_W    = 12,
  parameter int JACKPOT_VAL = 777
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_in,
  input  logic                spin_req,
  input  logic                cash_req,
  input  logic [BET_W-1:0]    bet,
  input  logic                res_valid,
  input  logic                won,
  input  logic [REEL_W-1:0]   out,
  input  logic                hopper_ack,
  output logic                start,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] last_win,
  output logic                busy,
  output logic                hopper_req
);

  localparam int PROD_W = BET_W + MULT_W;
  localparam int SUM_W  = ((CREDIT_W > PROD_W) ? CREDIT_W : PROD_W) + 2;
  localparam logic [SUM_W-1:0] C_MAX = {{(SUM_W-CREDIT_W){1'b0}}, {CREDIT_W{1'b1}}};

  credit_state_t        r_state;
  credit_state_t        w_state_nxt;
  logic [CREDIT_W-1:0]  r_credit;
  logic [CREDIT_W-1:0]  r_last_win;
  logic                 r_start;
  logic                 r_reject;
  logic                 r_busy;
  logic                 r_hopper;
  logic [BET_W-1:0]     r_bet;
  logic                 r_jackpot;

  logic [CREDIT_W-1:0]  w_credit_nxt;
  logic [CREDIT_W-1:0]  w_last_win_nxt;
  logic                 w_start_nxt;
  logic                 w_reject_nxt;
  logic                 w_go;
  logic                 w_bcd_done;
  logic [BCD_W-1:0]     w_bcd;
  logic                 w_triple;
  logic [MULT_W-1:0]    w_mult;
  logic [SUM_W-1:0]     w_credit_ext;
  logic [SUM_W-1:0]     w_coin_sum;
  logic [SUM_W-1:0]     w_prod;
  logic [SUM_W-1:0]     w_pay_sum;
  logic [CREDIT_W-1:0]  w_credit_coin;
  logic [CREDIT_W-1:0]  w_credit_debit;
  logic [CREDIT_W-1:0]  w_credit_ack;
  logic [CREDIT_W-1:0]  w_win;
  logic [CREDIT_W-1:0]  w_pay_credit;
  logic                 w_spin_ok;

  bin2bcd_seq u_bcd (
    .clk    (clk),
    .rst    (rst),
    .i_go   (w_go),
    .i_bin  (out),
    .o_done (w_bcd_done),
    .o_bcd  (w_bcd)
  );

  // Saturating arithmetic, all done in a width that cannot wrap
  assign w_credit_ext   = SUM_W'(r_credit);
  assign w_coin_sum     = w_credit_ext + SUM_W'(coin_in);
  assign w_credit_coin  = (w_coin_sum > C_MAX) ? C_MAX[CREDIT_W-1:0] : w_coin_sum[CREDIT_W-1:0];
  assign w_spin_ok      = (bet != '0) && (w_credit_ext >= SUM_W'(bet));
  // bet >= 1 here, so adding a coin after the debit cannot exceed the maximum
  assign w_credit_debit = r_credit - CREDIT_W'(bet) + CREDIT_W'(coin_in);
  // A coin landing with a hopper ack cancels it out
  assign w_credit_ack   = coin_in ? r_credit : (r_credit - CREDIT_W'(1));

  assign w_triple = (w_bcd[11:8] == w_bcd[7:4]) && (w_bcd[7:4] == w_bcd[3:0]);
  assign w_mult   = r_jackpot ? MULT_JACKPOT : (w_triple ? MULT_TRIPLE : MULT_WIN);
  assign w_prod   = SUM_W'(r_bet) * SUM_W'(w_mult);
  assign w_win    = (w_prod > C_MAX) ? C_MAX[CREDIT_W-1:0] : w_prod[CREDIT_W-1:0];
  assign w_pay_sum    = w_credit_ext + SUM_W'(w_win) + SUM_W'(coin_in);
  assign w_pay_credit = (w_pay_sum > C_MAX) ? C_MAX[CREDIT_W-1:0] : w_pay_sum[CREDIT_W-1:0];

  // Next state and next register values; coin credit is the default in every state
  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = w_credit_coin;
    w_last_win_nxt = r_last_win;
    w_start_nxt    = 1'b0;
    w_reject_nxt   = 1'b0;
    w_go           = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (spin_req) begin
          if (w_spin_ok) begin
            w_credit_nxt = w_credit_debit;
            w_start_nxt  = 1'b1;
            w_state_nxt  = WAIT_RES;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end else if (cash_req && (r_credit != '0)) begin
          w_state_nxt = CASHOUT;
        end
      end
      WAIT_RES: begin
        if (res_valid) begin
          if (won) begin
            w_go        = 1'b1;
            w_state_nxt = CONVERT;
          end else begin
            w_last_win_nxt = '0;
            w_state_nxt    = IDLE;
          end
        end
      end
      CONVERT: begin
        if (w_bcd_done) begin
          w_state_nxt = PAYOUT;
        end
      end
      PAYOUT: begin
        w_last_win_nxt = w_win;
        w_credit_nxt   = w_pay_credit;
        w_state_nxt    = IDLE;
      end
      CASHOUT: begin
        if (hopper_ack) begin
          w_credit_nxt = w_credit_ack;
          if (!coin_in && (r_credit == CREDIT_W'(1))) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and the spin result captured for the payout
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit   <= '0;
      r_last_win <= '0;
      r_start    <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
      r_hopper   <= 1'b0;
      r_bet      <= '0;
      r_jackpot  <= 1'b0;
    end else begin
      r_credit   <= w_credit_nxt;
      r_last_win <= w_last_win_nxt;
      r_start    <= w_start_nxt;
      r_reject   <= w_reject_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_hopper   <= (w_state_nxt == CASHOUT);
      if (w_go) begin
        r_bet     <= bet;
        r_jackpot <= (out == REEL_W'(JACKPOT_VAL));
      end
    end
  end

  assign start      = r_start;
  assign reject     = r_reject;
  assign credit     = r_credit;
  assign last_win   = r_last_win;
  assign busy       = r_busy;
  assign hopper_req = r_hopper;

endmodule

// File: tb/tb_slot_credit_ctrl.sv
// Bench for slot_credit_ctrl: abstract credit model checked every cycle, plus literal expectations.
// Latency: model credits a win on the 12th edge after res_valid is sampled.
// Backpressure: hopper acks are single-cycle pulses with random gaps.
module tb_slot_credit_ctrl;

  localparam int MAXC    = 4095;
  localparam int MD_IDLE = 0;
  localparam int MD_WAIT = 1;
  localparam int MD_CONV = 2;
  localparam int MD_CASH = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        coin_in = 1'b0;
  logic        spin_req = 1'b0;
  logic        cash_req = 1'b0;
  logic [3:0]  bet = 4'd0;
  logic        res_valid = 1'b0;
  logic        won = 1'b0;
  logic [9:0]  out = 10'd0;
  logic        hopper_ack = 1'b0;
  logic        start;
  logic        reject;
  logic [11:0] credit;
  logic [11:0] last_win;
  logic        busy;
  logic        hopper_req;

  int n_checks = 0;
  int n_fail   = 0;

  int m_credit = 0;
  int m_last_win = 0;
  int m_mode = MD_IDLE;
  int m_timer = 0;
  int m_pay = 0;
  bit m_start = 1'b0;
  bit m_reject = 1'b0;
  bit m_busy = 1'b0;
  bit m_hopper = 1'b0;

  always #5 clk = ~clk;

  slot_credit_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .coin_in    (coin_in),
    .spin_req   (spin_req),
    .cash_req   (cash_req),
    .bet        (bet),
    .res_valid  (res_valid),
    .won        (won),
    .out        (out),
    .hopper_ack (hopper_ack),
    .start      (start),
    .reject     (reject),
    .credit     (credit),
    .last_win   (last_win),
    .busy       (busy),
    .hopper_req (hopper_req)
  );

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  // Payout multiplier from the decimal reel value (low three digits for the triple test)
  function automatic int mult_of(input int v);
    int r;
    r = v % 1000;
    if (v == 777) return 50;
    if ((r / 100) == ((r / 10) % 10) && ((r / 10) % 10) == (r % 10)) return 10;
    return 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp_v);
    end
  endtask

  // Abstract model: balance as an integer, a mode, and a countdown to the payout
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_credit = 0; m_last_win = 0; m_mode = MD_IDLE; m_timer = 0; m_pay = 0;
      m_start = 1'b0; m_reject = 1'b0; m_busy = 1'b0; m_hopper = 1'b0;
    end else begin
      m_start = 1'b0;
      m_reject = 1'b0;
      case (m_mode)
        MD_IDLE: begin
          if (spin_req) begin
            if (bet != 4'd0 && m_credit >= int'(bet)) begin
              m_credit = m_credit - int'(bet) + int'(coin_in);
              m_start = 1'b1;
              m_mode = MD_WAIT;
            end else begin
              m_reject = 1'b1;
              m_credit = sat(m_credit + int'(coin_in));
            end
          end else begin
            if (cash_req && m_credit != 0) m_mode = MD_CASH;
            m_credit = sat(m_credit + int'(coin_in));
          end
        end
        MD_WAIT: begin
          if (res_valid) begin
            if (won) begin
              m_pay = sat(int'(bet) * mult_of(int'(out)));
              m_timer = 11;
              m_mode = MD_CONV;
            end else begin
              m_last_win = 0;
              m_mode = MD_IDLE;
            end
          end
          m_credit = sat(m_credit + int'(coin_in));
        end
        MD_CONV: begin
          m_timer--;
          if (m_timer == 0) begin
            m_last_win = m_pay;
            m_credit = sat(m_credit + m_pay + int'(coin_in));
            m_mode = MD_IDLE;
          end else begin
            m_credit = sat(m_credit + int'(coin_in));
          end
        end
        default: begin
          if (hopper_ack && !coin_in) begin
            m_credit--;
            if (m_credit == 0) m_mode = MD_IDLE;
          end else if (!hopper_ack) begin
            m_credit = sat(m_credit + int'(coin_in));
          end
        end
      endcase
      m_busy = (m_mode != MD_IDLE);
      m_hopper = (m_mode == MD_CASH);
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("cmp_start", int'(start), int'(m_start));
      chk("cmp_reject", int'(reject), int'(m_reject));
      chk("cmp_credit", int'(credit), m_credit);
      chk("cmp_last_win", int'(last_win), m_last_win);
      chk("cmp_busy", int'(busy), int'(m_busy));
      chk("cmp_hopper_req", int'(hopper_req), int'(m_hopper));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    coin_in = 1'b0; spin_req = 1'b0; cash_req = 1'b0;
    res_valid = 1'b0; won = 1'b0; hopper_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic coins(input int n);
    if (n > 0) begin
      coin_in = 1'b1;
      repeat (n) @(negedge clk);
      coin_in = 1'b0;
    end
  endtask

  task automatic win_case(input string tag, input bit fresh, input int c0, input int b,
                          input bit w, input int o, input bit pay_coin,
                          input int exp_mid, input int exp_win, input int exp_credit);
    if (fresh) do_reset();
    coins(c0);
    bet = 4'(b);
    spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    chk({tag, "_start"}, int'(start), 1);
    step();
    won = w; out = 10'(o); res_valid = 1'b1;
    step();
    res_valid = 1'b0; won = 1'b0;
    if (w) begin
      repeat (10) step();
      chk({tag, "_credit_before_payout"}, int'(credit), exp_mid);
      chk({tag, "_busy_before_payout"}, int'(busy), 1);
      coin_in = pay_coin;
      step();
      coin_in = 1'b0;
    end
    chk({tag, "_last_win"}, int'(last_win), exp_win);
    chk({tag, "_credit"}, int'(credit), exp_credit);
    chk({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_c[4];
    bit cf[4];
    bit eh[4];
    exp_c = '{2, 2, 1, 0};
    cf    = '{1'b0, 1'b1, 1'b0, 1'b0};
    eh    = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reset values, then 5 coins and a bet-3 spin that also carries a cash request
    do_reset();
    chk("rst_credit", int'(credit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hopper", int'(hopper_req), 0);
    coins(5);
    chk("coins5_credit", int'(credit), 5);
    bet = 4'd3;
    spin_req = 1'b1; cash_req = 1'b1;
    step();
    spin_req = 1'b0; cash_req = 1'b0;
    chk("spin_start", int'(start), 1);
    chk("spin_credit", int'(credit), 2);
    chk("spin_busy", int'(busy), 1);
    chk("spin_no_hopper", int'(hopper_req), 0);
    step();
    chk("spin_start_one_cycle", int'(start), 0);
    res_valid = 1'b1; won = 1'b0;
    step();
    res_valid = 1'b0;
    chk("loss_idle", int'(busy), 0);

    // Refused spins: insufficient credit, then zero bet; stray res_valid ignored
    spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    chk("rej_pulse", int'(reject), 1);
    chk("rej_no_start", int'(start), 0);
    chk("rej_credit", int'(credit), 2);
    step();
    chk("rej_one_cycle", int'(reject), 0);
    bet = 4'd0;
    spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    chk("rej_bet0", int'(reject), 1);
    res_valid = 1'b1; won = 1'b1; out = 10'd777;
    step();
    res_valid = 1'b0; won = 1'b0;
    chk("stray_res_credit", int'(credit), 2);

    // Payout patterns from credit 10 with bet 4
    win_case("jackpot", 1'b1, 10, 4, 1'b1, 777, 1'b0, 6, 200, 206);
    win_case("triple", 1'b1, 10, 4, 1'b1, 333, 1'b0, 6, 40, 46);
    win_case("loss_after_win", 1'b0, 0, 4, 1'b0, 0, 1'b0, 0, 0, 42);
    win_case("plain", 1'b1, 10, 4, 1'b1, 512, 1'b0, 6, 8, 14);
    win_case("plain_coin", 1'b1, 10, 4, 1'b1, 512, 1'b1, 6, 8, 15);
    win_case("loss", 1'b1, 10, 4, 1'b0, 0, 1'b0, 0, 0, 6);
    win_case("over999", 1'b1, 10, 4, 1'b1, 1000, 1'b0, 6, 40, 46);

    // Saturation at the top of the balance
    do_reset();
    coins(4095);
    chk("sat_fill", int'(credit), 4095);
    coins(1);
    chk("sat_coin_idle", int'(credit), 4095);
    win_case("sat_jackpot", 1'b0, 0, 4, 1'b1, 777, 1'b0, 4091, 200, 4095);
    coins(1);
    chk("sat_coin_after", int'(credit), 4095);

    // Cash-out: zero-balance request ignored, then 3 coins drained with random gaps
    do_reset();
    cash_req = 1'b1;
    step();
    cash_req = 1'b0;
    chk("cash_zero_ignored", int'(hopper_req), 0);
    coins(3);
    cash_req = 1'b1;
    step();
    cash_req = 1'b0;
    chk("cash_hopper_up", int'(hopper_req), 1);
    chk("cash_credit3", int'(credit), 3);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(3, 0)) step();
      if (k == 1) begin
        spin_req = 1'b1;
        step();
        spin_req = 1'b0;
        chk("cash_spin_ignored", int'(start) + int'(reject), 0);
      end
      hopper_ack = 1'b1; coin_in = cf[k];
      step();
      hopper_ack = 1'b0; coin_in = 1'b0;
      chk($sformatf("cash_credit_%0d", k), int'(credit), exp_c[k]);
      chk($sformatf("cash_hopper_%0d", k), int'(hopper_req), int'(eh[k]));
    end
    hopper_ack = 1'b1;
    step();
    hopper_ack = 1'b0;
    chk("cash_stray_ack", int'(credit), 0);
    chk("cash_idle", int'(busy), 0);

    // Asynchronous reset in the middle of a winning conversion
    do_reset();
    coins(10);
    bet = 4'd4;
    spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    step();
    res_valid = 1'b1; won = 1'b1; out = 10'd777;
    step();
    res_valid = 1'b0; won = 1'b0;
    repeat (4) step();
    chk("conv_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_start", int'(start), 0);
    chk("arst_reject", int'(reject), 0);
    chk("arst_credit", int'(credit), 0);
    chk("arst_last_win", int'(last_win), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_hopper", int'(hopper_req), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) step();
    chk("arst_no_payout", int'(credit), 0);
    chk("arst_no_last_win", int'(last_win), 0);
    spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    chk("arst_idle_reject", int'(reject), 1);
    coins(5);
    spin_req = 1'b1;
    step();
    spin_req = 1'b0;
    chk("arst_idle_start", int'(start), 1);
    chk("arst_idle_credit", int'(credit), 1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
